// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one double-dabble step per clock,
// start/done handshake, sign-magnitude handling and sticky overflow detection.

module bin_to_bcd_dig (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_IN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  ovf
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] shreg;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BIN_W-1:0] mag;
    logic [CW-1:0]    cnt;
    logic             sticky;
    logic             sign;

    // Per-digit add-3 correction, applied before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bin_to_bcd_dig u_dig (.d(scratch[4*g +: 4]), .q(adj[4*g +: 4]));
    end

    // Negation taken as unsigned so the most negative input yields its true magnitude
    always_comb begin
        mag = bin_in;
        if (SIGNED_IN != 0 && bin_in[BIN_W-1])
            mag = ~bin_in + BIN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            sign    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= mag;
                        sign    <= (SIGNED_IN != 0) && bin_in[BIN_W-1];
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CW'(BIN_W);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {scratch, shreg} <= {adj[BW-2:0], shreg, 1'b0};
                    sticky <= sticky | adj[BW-1];
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_FINISH;
                end
                S_FINISH: begin
                    bcd_out <= sticky ? {DIGITS{4'h9}} : scratch;
                    ovf     <= sticky;
                    // A zero magnitude never reports a sign
                    neg     <= sign && (sticky || scratch != '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations, table vectors, random vectors
// against an arithmetic reference, and hand-written handshake/reset sequences.

module tb_bin_to_bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st [3];
    logic [15:0] bi [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        neg_w [3];
    logic        ovf_w [3];
    logic [19:0] bcd0, bcd2;
    logic [15:0] bcd1;

    int          sel = 0;
    logic        busy_s, done_s, neg_s, ovf_s;
    logic [19:0] bcd_s;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Default: 16 bits, 5 digits, signed
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .bin_in(bi[0]), .busy(busy_w[0]),
        .done(done_w[0]), .bcd_out(bcd0), .neg(neg_w[0]), .ovf(ovf_w[0]));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED_IN(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .bin_in(bi[1]), .busy(busy_w[1]),
        .done(done_w[1]), .bcd_out(bcd1), .neg(neg_w[1]), .ovf(ovf_w[1]));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_IN(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .bin_in(bi[2]), .busy(busy_w[2]),
        .done(done_w[2]), .bcd_out(bcd2), .neg(neg_w[2]), .ovf(ovf_w[2]));

    always_comb begin
        busy_s = busy_w[0];
        done_s = done_w[0];
        neg_s  = neg_w[0];
        ovf_s  = ovf_w[0];
        bcd_s  = bcd0;
        case (sel)
            1: begin
                busy_s = busy_w[1]; done_s = done_w[1]; neg_s = neg_w[1];
                ovf_s = ovf_w[1]; bcd_s = {4'h0, bcd1};
            end
            2: begin
                busy_s = busy_w[2]; done_s = done_w[2]; neg_s = neg_w[2];
                ovf_s = ovf_w[2]; bcd_s = bcd2;
            end
            default: ;
        endcase
    end

    typedef struct {
        int          k;
        logic [15:0] v;
        logic [19:0] b;
        logic        n;
        logic        o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: magnitude by plain arithmetic, digits by repeated division
    function automatic void model(input int k, input logic [15:0] v,
                                  output logic [19:0] b, output logic n, output logic o);
        int d   = (k == 1) ? 4 : 5;
        int lim = (k == 1) ? 10000 : 100000;
        int mag = (k == 0 && v[15]) ? 65536 - int'(v) : int'(v);
        o = (mag >= lim);
        n = (k == 0) && v[15] && (mag != 0);
        b = '0;
        for (int i = 0; i < d; i++) begin
            if (o) b[4*i +: 4] = 4'h9;
            else begin
                b[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
        end
    endfunction

    // Called at a negedge; pulses start for one edge and waits (bounded) for done
    task automatic convert(input int k, input logic [15:0] v, output int bcnt, output int cyc);
        sel = k;
        bi[k] = v;
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        bcnt = 0;
        cyc = 0;
        while (!done_s && cyc < 40) begin
            if (busy_s) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_check(input string nm, input int k, input logic [15:0] v,
                             input logic [19:0] eb, input logic en, input logic eo);
        int bcnt, cyc;
        convert(k, v, bcnt, cyc);
        chk({nm, ".done_seen"}, 32'(done_s), 32'd1);
        chk({nm, ".latency"}, 32'(cyc), 32'd17);
        chk({nm, ".busy_cycles"}, 32'(bcnt), 32'd17);
        chk({nm, ".bcd"}, 32'(bcd_s), 32'(eb));
        chk({nm, ".neg"}, 32'(neg_s), 32'(en));
        chk({nm, ".ovf"}, 32'(ovf_s), 32'(eo));
        @(negedge clk);
        chk({nm, ".done_width"}, 32'(done_s), 32'd0);
        chk({nm, ".bcd_hold"}, 32'(bcd_s), 32'(eb));
    endtask

    initial begin
        vec_t        tbl [7];
        logic [19:0] eb;
        logic        en, eo;
        logic [15:0] v;
        int          bcnt, cyc, n;
        logic        seen;

        tbl[0] = '{0, 16'h0000, 20'h00000, 1'b0, 1'b0};
        tbl[1] = '{0, 16'h3039, 20'h12345, 1'b0, 1'b0};
        tbl[2] = '{0, 16'hFFFF, 20'h00001, 1'b1, 1'b0};
        tbl[3] = '{0, 16'h8000, 20'h32768, 1'b1, 1'b0};
        tbl[4] = '{1, 16'd10000, 20'h09999, 1'b0, 1'b1};
        tbl[5] = '{1, 16'd9999, 20'h09999, 1'b0, 1'b0};
        tbl[6] = '{2, 16'hFFFF, 20'h65535, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            bi[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #0;
            chk("reset.busy", 32'(busy_s), 32'd0);
            chk("reset.done", 32'(done_s), 32'd0);
            chk("reset.bcd", 32'(bcd_s), 32'd0);
            chk("reset.neg_ovf", {30'd0, neg_s, ovf_s}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_check($sformatf("tbl%0d", i), tbl[i].k, tbl[i].v, tbl[i].b, tbl[i].n, tbl[i].o);

        // Random vectors on the signed 5-digit and unsigned 4-digit instances
        for (int i = 0; i < 24; i++) begin
            v = 16'($urandom);
            if (i % 6 == 0) v = 16'(32768 + $urandom_range(0, 3));
            model(0, v, eb, en, eo);
            run_check($sformatf("rnd0_%h", v), 0, v, eb, en, eo);
        end
        for (int i = 0; i < 12; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(9990, 10010)) : 16'($urandom);
            model(1, v, eb, en, eo);
            run_check($sformatf("rnd1_%h", v), 1, v, eb, en, eo);
        end

        // start while busy is ignored; start during the done cycle is accepted
        sel = 0;
        bi[0] = 16'd42;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (4) @(negedge clk);
        bi[0] = 16'd7;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        n = 0;
        while (!done_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ignore.done_seen", 32'(done_s), 32'd1);
        chk("ignore.bcd", 32'(bcd_s), 32'h00042);
        convert(0, 16'd7, bcnt, cyc);
        chk("b2b.done_seen", 32'(done_s), 32'd1);
        chk("b2b.latency", 32'(cyc), 32'd17);
        chk("b2b.bcd", 32'(bcd_s), 32'h00007);
        @(negedge clk);

        // Asynchronous reset mid-conversion aborts without a done pulse
        bi[0] = 16'd999;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy_s), 32'd0);
        chk("abort.done", 32'(done_s), 32'd0);
        chk("abort.bcd", 32'(bcd_s), 32'd0);
        chk("abort.neg_ovf", {30'd0, neg_s, ovf_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done_s) seen = 1'b1;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        run_check("after_abort", 0, 16'd999, 20'h00999, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
